sram_controller: RTL and testbench

Sequences the off-chip 16-bit SRAM on behalf of the MEM stage. It converts one 32-bit word load or store, qualified by the decoded mem_read/mem_write, into two timed 16-bit SRAM accesses. It drives ready low while an access is in flight, and the hazard/freeze logic uses ~ready to stall every pipeline register. It sits between the MEM-stage register outputs and the top-level SRAM pins.

---
 rtl/sram_controller_pkg.sv | 22 ++
 rtl/sram_rd_cache.sv | 34 +++
 rtl/sram_controller.sv | 142 ++++++++++++++
 tb/tb_sram_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the 16-bit off-chip SRAM sequencer.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_e;

    localparam int unsigned SRAM_BASE_ADDR   = 32'd1024;
    localparam int unsigned SRAM_WAIT_CYCLES = 5;
    localparam int unsigned SRAM_ADDR_W      = 18;
    localparam int unsigned SRAM_DQ_W        = 16;
    localparam int unsigned SRAM_WORD_W      = 32;

    // Byte offset of a CPU address inside the SRAM window (wraps, no range check).
    function automatic logic [31:0] byte_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_rd_cache.sv
// Single-entry read cache for sram_controller: valid/tag/data register with hit compare.
module sram_rd_cache
    import sram_controller_pkg::*;
#(
    parameter int unsigned WORD_IDX_W = 17
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_IDX_W-1:0]  lookup_word,
    output logic                   hit_c,
    output logic [SRAM_WORD_W-1:0] data,
    input  logic                   fill_en,
    input  logic [WORD_IDX_W-1:0]  fill_word,
    input  logic [SRAM_WORD_W-1:0] fill_data
);

    logic                  valid;
    logic [WORD_IDX_W-1:0] tag;

    assign hit_c = valid && (tag == lookup_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_word;
            data  <= fill_data;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two timed 16-bit SRAM accesses.
// Optional single-entry read cache enabled by defining SRAM_RD_CACHE_EN.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int unsigned BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int unsigned SRAM_AW     = SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [SRAM_WORD_W-1:0] write_data,
    output logic [SRAM_WORD_W-1:0] read_data,
    output logic                   ready,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [SRAM_DQ_W-1:0]   sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
    output logic                   sram_we_n
);

    localparam int unsigned CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WORD_IDX_W = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(WAIT_CYCLES - 2);

    sram_state_e             state;
    logic [CNT_W-1:0]        cnt;
    logic                    op_write;
    logic [WORD_IDX_W-1:0]   word_q;
    logic [SRAM_WORD_W-1:0]  data_q;

    logic [31:0]             offset_c;
    logic [WORD_IDX_W-1:0]   req_word_c;
    logic                    req_c;
    logic                    last_c;
    logic                    cache_hit_c;
    logic [SRAM_WORD_W-1:0]  cache_data_c;
    logic                    unused_offset_bits;

    assign offset_c           = byte_offset(address, 32'(BASE_ADDR));
    assign req_word_c         = offset_c[SRAM_AW:2];
    assign unused_offset_bits = ^{offset_c[31:SRAM_AW+1], offset_c[1:0]};
    assign req_c              = rd_en | wr_en;
    assign last_c             = (cnt == CNT_LAST);

    // Pipeline stall: low from the request cycle until the completion cycle.
    assign ready = ((state == IDLE) && !req_c) || (state == DONE);

`ifdef SRAM_RD_CACHE_EN
    logic [WORD_IDX_W-1:0]  lookup_word_c;
    logic                   fill_en_c;
    logic [SRAM_WORD_W-1:0] fill_data_c;

    // Look up the incoming word in IDLE, the latched word when deciding the DONE update.
    assign lookup_word_c = (state == IDLE) ? req_word_c : word_q;
    assign fill_en_c     = (state == DONE) && (!op_write || cache_hit_c);
    assign fill_data_c   = op_write ? data_q : read_data;

    sram_rd_cache #(
        .WORD_IDX_W (WORD_IDX_W)
    ) u_rd_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_word (lookup_word_c),
        .hit_c       (cache_hit_c),
        .data        (cache_data_c),
        .fill_en     (fill_en_c),
        .fill_word   (word_q),
        .fill_data   (fill_data_c)
    );
`else
    assign cache_hit_c  = 1'b0;
    assign cache_data_c = '0;
`endif

    // Sequencer: pin values are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_write    <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_c) begin
                        op_write <= wr_en;
                        word_q   <= req_word_c;
                        data_q   <= write_data;
                        cnt      <= '0;
                        if (rd_en && !wr_en && cache_hit_c) begin
                            read_data <= cache_data_c;
                            state     <= DONE;
                        end else begin
                            state       <= LOW;
                            sram_addr   <= {req_word_c, 1'b0};
                            sram_dq_oe  <= wr_en;
                            sram_dq_out <= write_data[15:0];
                            sram_we_n   <= !wr_en;
                        end
                    end
                end
                LOW, HIGH: begin
                    if (last_c) begin
                        cnt <= '0;
                        if (!op_write) begin
                            if (state == LOW) read_data[15:0]  <= sram_dq_in;
                            else              read_data[31:16] <= sram_dq_in;
                        end
                        if (state == LOW) begin
                            state       <= HIGH;
                            sram_addr   <= {word_q, 1'b1};
                            sram_dq_out <= data_q[31:16];
                            sram_we_n   <= !op_write;
                        end else begin
                            state      <= DONE;
                            sram_dq_oe <= 1'b0;
                            sram_we_n  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Strobe released for the final cycle of each half so data is held past we_n rise.
                        sram_we_n <= !op_write || (cnt == CNT_HOLD);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a cycle-count model and a pin-level SRAM.
module tb_sram_controller;

    localparam int          W      = 5;
    localparam int unsigned BASE   = 1024;
    localparam int          AW     = 18;
    localparam int          DONE_T = 2 * W + 1;
`ifdef SRAM_RD_CACHE_EN
    localparam bit HAS_CACHE = 1'b1;
`else
    localparam bit HAS_CACHE = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    sram_controller #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin-level SRAM: latches on the rising edge of we_n, reads asynchronously.
    logic [15:0] env_mem [0:1023];
    logic [15:0] exp_mem [0:1023];
    assign sram_dq_in = env_mem[sram_addr[9:0]];
    always @(posedge sram_we_n) begin
        if (rst_n === 1'b1) env_mem[sram_addr[9:0]] = sram_dq_out;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Transaction model: position t counts cycles since the access was accepted.
    int          t = 0;
    bit          m_write;
    logic [16:0] m_word;
    logic [31:0] m_data;
    logic [31:0] m_rd = '0;
    bit          c_valid = 1'b0;
    logic [16:0] c_tag;
    logic [31:0] c_data;

    always @(negedge clk) begin
        int          half;
        int          sub;
        logic [31:0] off;
        logic [17:0] ha;
        if (!rst_n) begin
            t       = 0;
            m_rd    = '0;
            c_valid = 1'b0;
            check("rst_we_n", 32'(sram_we_n), 32'd1);
            check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
            check("rst_read_data", read_data, 32'd0);
            check("rst_ready", 32'(ready), 32'(!(rd_en || wr_en)));
        end else begin
            if (t == 0) begin
                check("idle_ready", 32'(ready), 32'(!(rd_en || wr_en)));
                check("idle_we_n", 32'(sram_we_n), 32'd1);
                check("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
            end else if (t < DONE_T) begin
                half = (t - 1) / W;
                sub  = (t - 1) % W;
                ha   = {m_word, (half == 1)};
                check("busy_ready", 32'(ready), 32'd0);
                check("sram_addr", 32'(sram_addr), 32'(ha));
                check("dq_oe", 32'(sram_dq_oe), 32'(m_write));
                check("we_n", 32'(sram_we_n), 32'(!m_write || (sub == W - 1)));
                if (m_write)
                    check("dq_out", 32'(sram_dq_out), (half == 1) ? 32'(m_data[31:16]) : 32'(m_data[15:0]));
            end else begin
                check("done_ready", 32'(ready), 32'd1);
                check("done_we_n", 32'(sram_we_n), 32'd1);
                check("done_dq_oe", 32'(sram_dq_oe), 32'd0);
            end
            check("read_data", read_data, m_rd);

            if (t == 0) begin
                if (rd_en || wr_en) begin
                    m_write = wr_en;
                    off     = address - 32'(BASE);
                    m_word  = off[18:2];
                    m_data  = write_data;
                    if (HAS_CACHE && !wr_en && c_valid && c_tag == m_word) begin
                        m_rd = c_data;
                        t    = DONE_T;
                    end else begin
                        t = 1;
                    end
                end
            end else if (t < DONE_T) begin
                ha = {m_word, 1'b0};
                if (t == W && !m_write) m_rd[15:0] = exp_mem[ha[9:0]];
                if (t == 2 * W) begin
                    if (m_write) begin
                        exp_mem[ha[9:0]]      = m_data[15:0];
                        exp_mem[ha[9:0] + 10'd1] = m_data[31:16];
                    end else begin
                        m_rd[31:16] = exp_mem[ha[9:0] + 10'd1];
                    end
                end
                t++;
            end else begin
                ha = {m_word, 1'b0};
                if (m_write) begin
                    check("mem_lo", 32'(env_mem[ha[9:0]]), 32'(exp_mem[ha[9:0]]));
                    check("mem_hi", 32'(env_mem[ha[9:0] + 10'd1]), 32'(exp_mem[ha[9:0] + 10'd1]));
                end
                if (HAS_CACHE) begin
                    if (!m_write) begin
                        c_valid = 1'b1;
                        c_tag   = m_word;
                        c_data  = m_rd;
                    end else if (c_valid && c_tag == m_word) begin
                        c_data = m_data;
                    end
                end
                t = 0;
            end
        end
    end

    // Hold a request until ready rises (DONE), then release it after that edge.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output int low, output int wl);
        bit done;
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        low  = 0;
        wl   = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!sram_we_n) wl++;
            if (ready) done = 1'b1;
            else low++;
        end
        check("access_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        int low;
        int wl;
        rst_n      = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = '0;
            exp_mem[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("por_ready", 32'(ready), 32'd1);
        check("por_we_n", 32'(sram_we_n), 32'd1);
        #1 rst_n = 1'b1;

        // Mid-cycle reset with no request takes effect without a clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_we_n", 32'(sram_we_n), 32'd1);
        check("async_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("async_ready", 32'(ready), 32'd1);
        check("async_read_data", read_data, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, low, wl);
        check("st_ready_low", 32'(low), 32'd11);
        check("st_we_low", 32'(wl), 32'd8);
        check("st_mem2", 32'(env_mem[2]), 32'h0000BEEF);
        check("st_mem3", 32'(env_mem[3]), 32'h0000DEAD);

        do_access(1'b1, 1'b0, 32'd1028, 32'h0, low, wl);
        check("ld_ready_low", 32'(low), 32'd11);
        check("ld_data", read_data, 32'hDEADBEEF);

        do_access(1'b1, 1'b0, 32'd1028, 32'h0, low, wl);
        check("ld2_ready_low", 32'(low), HAS_CACHE ? 32'd1 : 32'd11);
        check("ld2_data", read_data, 32'hDEADBEEF);

        do_access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, low, wl);
        check("st2_ready_low", 32'(low), 32'd11);
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, low, wl);
        check("ld3_ready_low", 32'(low), HAS_CACHE ? 32'd1 : 32'd11);
        check("ld3_data", read_data, 32'hCAFEF00D);

        do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, low, wl);
        check("both_we_low", 32'(wl), 32'd8);
        check("both_mem0", 32'(env_mem[0]), 32'h00005678);
        check("both_mem1", 32'(env_mem[1]), 32'h00001234);
        check("both_rd_hold", read_data, 32'hCAFEF00D);

        do_access(1'b1, 1'b0, 32'd1025, 32'h0, low, wl);
        check("ld_lowbits_low", 32'(low), 32'd11);
        check("ld_lowbits_data", read_data, 32'h12345678);

        do_access(1'b0, 1'b1, 32'd1020, 32'h11112222, low, wl);
        check("wrap_mem_lo", 32'(env_mem[1022]), 32'h00002222);
        check("wrap_mem_hi", 32'(env_mem[1023]), 32'h00001111);

        // Reset in the second cycle of the high half of a store.
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hA5A55A5A;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        check("pre_rst_addr", 32'(sram_addr), 32'd9);
        #1;
        wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        check("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_access(1'b0, 1'b1, 32'd1044, 32'h0BADF00D, low, wl);
        check("post_rst_ready_low", 32'(low), 32'd11);
        check("post_rst_mem10", 32'(env_mem[10]), 32'h0000F00D);
        check("post_rst_mem11", 32'(env_mem[11]), 32'h00000BAD);
        do_access(1'b1, 1'b0, 32'd1047, 32'h0, low, wl);
        check("post_rst_ld_low", 32'(low), 32'd11);
        check("post_rst_ld_data", read_data, 32'h0BADF00D);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
